// File: rtl/sw_scoring_array.sv
// Smith-Waterman local-alignment scorer with affine gaps: a systolic row of PEs
// scores a streamed target against a run-time-length query and reports the best cell.
module sw_scoring_array #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 64,
    parameter int LOG_LENGTH  = $clog2(LENGTH),
    parameter int TPOS_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    input  logic                   start,
    input  logic [LOG_LENGTH:0]    q_len,
    input  logic [2*LENGTH-1:0]    query,
    output logic                   busy,
    input  logic                   t_valid,
    input  logic [1:0]             t_data,
    input  logic                   t_last,
    output logic                   t_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic [TPOS_WIDTH-1:0]  res_t_pos,
    output logic [LOG_LENGTH:0]    res_q_pos
);
    localparam int QW = LOG_LENGTH + 1;
    localparam logic [QW-1:0]         LEN_Q = QW'(LENGTH);
    localparam logic [QW-1:0]         ONE_Q = QW'(1);
    localparam logic [TPOS_WIDTH-1:0] ONE_T = TPOS_WIDTH'(1);

    typedef logic [SCORE_WIDTH-1:0] score_t;
    typedef logic [TPOS_WIDTH-1:0]  tpos_t;
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_SCAN, S_REPORT} state_t;

    function automatic score_t sub_sat(input score_t a, input score_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic score_t add_sat(input score_t a, input score_t b);
        logic [SCORE_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_WIDTH] ? '1 : s[SCORE_WIDTH-1:0];
    endfunction

    function automatic score_t max2(input score_t a, input score_t b);
        return (a > b) ? a : b;
    endfunction

    state_t            state_q, state_d;
    logic [QW-1:0]     q_len_q, q_len_d;
    logic [QW-1:0]     cnt_q, cnt_d;
    logic [2*LENGTH-1:0] query_q, query_d;
    score_t            match_q, match_d, mismatch_q, mismatch_d;
    score_t            gap_open_q, gap_open_d, gap_extend_q, gap_extend_d;
    tpos_t             t_idx_q, t_idx_d, t_idx_inc;

    score_t            cand_s_q, cand_s_d;
    tpos_t             cand_t_q, cand_t_d;
    logic [QW-1:0]     cand_p_q, cand_p_d;
    logic              cand_vld_q, cand_vld_d;
    score_t            res_s_q, res_s_d;
    tpos_t             res_t_q, res_t_d;
    logic [QW-1:0]     res_p_q, res_p_d;

    logic              start_ok;
    logic              hs;
    logic              cand_better;

    // Per-PE state: own H(i-1,j)/F(i-1,j), values forwarded to the right neighbour, local best
    score_t h_q [LENGTH];
    score_t h_d [LENGTH];
    score_t hd_q [LENGTH];
    score_t hd_d [LENGTH];
    score_t e_q [LENGTH];
    score_t e_d [LENGTH];
    score_t f_q [LENGTH];
    score_t f_d [LENGTH];
    logic [1:0] base_q [LENGTH];
    logic [1:0] base_d [LENGTH];
    tpos_t  tpos_q [LENGTH];
    tpos_t  tpos_d [LENGTH];
    logic   vld_q [LENGTH];
    logic   vld_d [LENGTH];
    score_t pe_best_s_q [LENGTH];
    score_t pe_best_s_d [LENGTH];
    tpos_t  pe_best_t_q [LENGTH];
    tpos_t  pe_best_t_d [LENGTH];

    score_t     in_h [LENGTH];
    score_t     in_e [LENGTH];
    score_t     in_diag [LENGTH];
    logic [1:0] in_base [LENGTH];
    tpos_t      in_tpos [LENGTH];
    logic       in_vld [LENGTH];

    assign t_idx_inc = (&t_idx_q) ? t_idx_q : (t_idx_q + ONE_T);

    // PE0 sees the column-0 boundary (all zero) and takes the base straight from the stream
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_pe_in
        if (gi == 0) begin : g_first
            assign in_h[gi]    = '0;
            assign in_e[gi]    = '0;
            assign in_diag[gi] = '0;
            assign in_base[gi] = t_data;
            assign in_tpos[gi] = t_idx_inc;
            assign in_vld[gi]  = hs;
        end else begin : g_chain
            assign in_h[gi]    = h_q[gi-1];
            assign in_e[gi]    = e_q[gi-1];
            assign in_diag[gi] = hd_q[gi-1];
            assign in_base[gi] = base_q[gi-1];
            assign in_tpos[gi] = tpos_q[gi-1];
            assign in_vld[gi]  = vld_q[gi-1];
        end
    end

    always_comb begin
        for (int j = 0; j < LENGTH; j++) begin
            h_d[j]         = h_q[j];
            hd_d[j]        = hd_q[j];
            e_d[j]         = e_q[j];
            f_d[j]         = f_q[j];
            base_d[j]      = base_q[j];
            tpos_d[j]      = tpos_q[j];
            vld_d[j]       = in_vld[j];
            pe_best_s_d[j] = pe_best_s_q[j];
            pe_best_t_d[j] = pe_best_t_q[j];
            if (in_vld[j]) begin
                e_d[j]    = max2(sub_sat(in_h[j], gap_open_q), sub_sat(in_e[j], gap_extend_q));
                f_d[j]    = max2(sub_sat(h_q[j], gap_open_q), sub_sat(f_q[j], gap_extend_q));
                h_d[j]    = max2(max2((in_base[j] == query_q[2*j +: 2]) ?
                                      add_sat(in_diag[j], match_q) :
                                      sub_sat(in_diag[j], mismatch_q),
                                      e_d[j]), f_d[j]);
                hd_d[j]   = h_q[j];
                base_d[j] = in_base[j];
                tpos_d[j] = in_tpos[j];
                if (h_d[j] > pe_best_s_q[j]) begin
                    pe_best_s_d[j] = h_d[j];
                    pe_best_t_d[j] = in_tpos[j];
                end
            end
            if (start_ok) begin
                h_d[j]         = '0;
                hd_d[j]        = '0;
                e_d[j]         = '0;
                f_d[j]         = '0;
                base_d[j]      = '0;
                tpos_d[j]      = '0;
                vld_d[j]       = 1'b0;
                pe_best_s_d[j] = '0;
                pe_best_t_d[j] = '0;
            end
        end
    end

    assign cand_better = (cand_s_q > res_s_q) ||
                         ((cand_s_q == res_s_q) && ((cand_t_q < res_t_q) ||
                          ((cand_t_q == res_t_q) && (cand_p_q < res_p_q))));

    always_comb begin
        state_d      = state_q;
        q_len_d      = q_len_q;
        cnt_d        = cnt_q;
        query_d      = query_q;
        match_d      = match_q;
        mismatch_d   = mismatch_q;
        gap_open_d   = gap_open_q;
        gap_extend_d = gap_extend_q;
        t_idx_d      = t_idx_q;
        cand_s_d     = cand_s_q;
        cand_t_d     = cand_t_q;
        cand_p_d     = cand_p_q;
        cand_vld_d   = 1'b0;
        res_s_d      = res_s_q;
        res_t_d      = res_t_q;
        res_p_d      = res_p_q;
        start_ok     = 1'b0;
        hs           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (q_len != '0)) begin
                    start_ok     = 1'b1;
                    q_len_d      = (q_len > LEN_Q) ? LEN_Q : q_len;
                    query_d      = query;
                    match_d      = match;
                    mismatch_d   = mismatch;
                    gap_open_d   = gap_open;
                    gap_extend_d = gap_extend;
                    t_idx_d      = '0;
                    res_s_d      = '0;
                    res_t_d      = '0;
                    res_p_d      = '0;
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                hs = t_valid;
                if (t_valid) begin
                    t_idx_d = t_idx_inc;
                    if (t_last) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == (q_len_q - ONE_Q)) begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + ONE_Q;
                end
            end
            S_SCAN: begin
                // Registered read of one PE per cycle; the merge runs one cycle behind it
                if (cnt_q == q_len_q) begin
                    state_d = S_REPORT;
                end else begin
                    cand_vld_d = 1'b1;
                    cand_s_d   = pe_best_s_q[cnt_q[LOG_LENGTH-1:0]];
                    cand_t_d   = pe_best_t_q[cnt_q[LOG_LENGTH-1:0]];
                    cand_p_d   = cnt_q + ONE_Q;
                    cnt_d      = cnt_q + ONE_Q;
                end
                if (cand_vld_q && cand_better) begin
                    res_s_d = cand_s_q;
                    res_t_d = cand_t_q;
                    res_p_d = cand_p_q;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            q_len_q      <= '0;
            cnt_q        <= '0;
            query_q      <= '0;
            match_q      <= '0;
            mismatch_q   <= '0;
            gap_open_q   <= '0;
            gap_extend_q <= '0;
            t_idx_q      <= '0;
            cand_s_q     <= '0;
            cand_t_q     <= '0;
            cand_p_q     <= '0;
            cand_vld_q   <= 1'b0;
            res_s_q      <= '0;
            res_t_q      <= '0;
            res_p_q      <= '0;
            for (int j = 0; j < LENGTH; j++) begin
                h_q[j]         <= '0;
                hd_q[j]        <= '0;
                e_q[j]         <= '0;
                f_q[j]         <= '0;
                base_q[j]      <= '0;
                tpos_q[j]      <= '0;
                vld_q[j]       <= 1'b0;
                pe_best_s_q[j] <= '0;
                pe_best_t_q[j] <= '0;
            end
        end else begin
            state_q      <= state_d;
            q_len_q      <= q_len_d;
            cnt_q        <= cnt_d;
            query_q      <= query_d;
            match_q      <= match_d;
            mismatch_q   <= mismatch_d;
            gap_open_q   <= gap_open_d;
            gap_extend_q <= gap_extend_d;
            t_idx_q      <= t_idx_d;
            cand_s_q     <= cand_s_d;
            cand_t_q     <= cand_t_d;
            cand_p_q     <= cand_p_d;
            cand_vld_q   <= cand_vld_d;
            res_s_q      <= res_s_d;
            res_t_q      <= res_t_d;
            res_p_q      <= res_p_d;
            h_q          <= h_d;
            hd_q         <= hd_d;
            e_q          <= e_d;
            f_q          <= f_d;
            base_q       <= base_d;
            tpos_q       <= tpos_d;
            vld_q        <= vld_d;
            pe_best_s_q  <= pe_best_s_d;
            pe_best_t_q  <= pe_best_t_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign t_ready   = (state_q == S_STREAM);
    assign res_valid = (state_q == S_REPORT);
    assign res_score = res_s_q;
    assign res_t_pos = res_t_q;
    assign res_q_pos = res_p_q;

endmodule

// File: tb/tb_sw_scoring_array.sv
// Directed bench for sw_scoring_array: a default-size engine and a 4-bit, 8-PE
// engine driven in lockstep from the same stimulus.
module tb_sw_scoring_array;
    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  match, mismatch, gap_open, gap_extend;
    logic         start;
    logic [6:0]   q_len;
    logic [127:0] query;
    logic         busy, t_ready, res_valid;
    logic         t_valid, t_last, res_ready;
    logic [1:0]   t_data;
    logic [11:0]  res_score;
    logic [15:0]  res_t_pos;
    logic [6:0]   res_q_pos;
    logic         b_busy, b_t_ready, b_res_valid;
    logic [3:0]   b_res_score;
    logic [15:0]  b_res_t_pos;
    logic [3:0]   b_res_q_pos;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sw_scoring_array dut (
        .clk(clk), .rst(rst),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .start(start), .q_len(q_len), .query(query), .busy(busy),
        .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ready(t_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_t_pos(res_t_pos), .res_q_pos(res_q_pos)
    );

    sw_scoring_array #(.SCORE_WIDTH(4), .LENGTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .match(match[3:0]), .mismatch(mismatch[3:0]),
        .gap_open(gap_open[3:0]), .gap_extend(gap_extend[3:0]),
        .start(start), .q_len(q_len[3:0]), .query(query[15:0]), .busy(b_busy),
        .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ready(b_t_ready),
        .res_valid(b_res_valid), .res_ready(res_ready),
        .res_score(b_res_score), .res_t_pos(b_res_t_pos), .res_q_pos(b_res_q_pos)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [6:0] ql, input logic [127:0] q);
        q_len = ql;
        query = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_t_ready", t_ready, 1'b1);
        chk("start_b_busy", b_busy, 1'b1);
    endtask

    // Returns at the cycle after the t_last handshake.
    task automatic send_target(input logic [31:0] bases, input int n, input bit bubbles);
        int idx = 0;
        int guard = 0;
        bit toggle = 1'b0;
        bit hs;
        while (idx < n && guard < 200) begin
            t_valid = bubbles ? toggle : 1'b1;
            toggle  = !toggle;
            t_data  = bases[2*idx +: 2];
            t_last  = (idx == n - 1);
            hs      = t_valid && t_ready;
            @(negedge clk);
            if (hs) idx++;
            guard++;
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
        chk("stream_bases_accepted", idx, n);
    endtask

    task automatic wait_result(input string tag, input int exp_s, input int exp_t,
                               input int exp_q, input int exp_bs, input int exp_lat);
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        $display("result %s: score=%0d t_pos=%0d q_pos=%0d latency=%0d b_score=%0d",
                 tag, res_score, res_t_pos, res_q_pos, n, b_res_score);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_score"}, res_score, exp_s);
        chk({tag, "_t_pos"}, res_t_pos, exp_t);
        chk({tag, "_q_pos"}, res_q_pos, exp_q);
        chk({tag, "_b_valid"}, b_res_valid, 1'b1);
        chk({tag, "_b_score"}, b_res_score, exp_bs);
        chk({tag, "_b_t_pos"}, b_res_t_pos, exp_t);
        chk({tag, "_b_q_pos"}, b_res_q_pos, exp_q);
        if (res_ready) begin
            @(negedge clk);
            chk({tag, "_done_busy"}, busy, 1'b0);
            chk({tag, "_done_valid"}, res_valid, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; q_len = '0; query = '0;
        t_valid = 1'b0; t_data = '0; t_last = 1'b0; res_ready = 1'b1;
        match = 12'd2; mismatch = 12'd1; gap_open = 12'd3; gap_extend = 12'd1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_t_ready", t_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_score", res_score, 0);
        chk("rst_res_t_pos", res_t_pos, 0);
        chk("rst_res_q_pos", res_q_pos, 0);
        chk("rst_b_busy", b_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // q_len of zero must not start a run
        q_len = 7'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("qlen0_ignored", busy, 1'b0);

        // Exact match ACGT / ACGT
        do_start(7'd4, 128'h9C);
        send_target(32'h9C, 4, 1'b0);
        wait_result("exact", 8, 4, 4, 8, 9);

        // No hit AAAA / TTTT
        do_start(7'd4, 128'h00);
        send_target(32'hAA, 4, 1'b0);
        wait_result("nohit", 0, 0, 0, 0, 9);

        // Affine gap ACGT / ACGGT with cheap gaps
        gap_open = 12'd1; gap_extend = 12'd1;
        do_start(7'd4, 128'h9C);
        send_target(32'h25C, 5, 1'b0);
        wait_result("affine", 7, 5, 4, 7, 9);
        gap_open = 12'd3;

        // Tie: query AA, target A; PE0 wins on q_pos
        do_start(7'd2, 128'h0);
        send_target(32'h0, 1, 1'b0);
        wait_result("tie", 2, 1, 1, 2, 5);

        // Flow control: bubbles, stray start while busy, res_ready held low
        res_ready = 1'b0;
        do_start(7'd4, 128'h9C);
        q_len = 7'd2; query = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flow_busy_after_stray_start", busy, 1'b1);
        send_target(32'h9C, 4, 1'b1);
        wait_result("flow", 8, 4, 4, 8, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("flow_hold_valid", res_valid, 1'b1);
            chk("flow_hold_score", res_score, 8);
            chk("flow_hold_t_pos", res_t_pos, 4);
            chk("flow_hold_q_pos", res_q_pos, 4);
        end
        res_ready = 1'b1; start = 1'b1; q_len = 7'd4; query = 128'h9C;
        @(negedge clk);
        start = 1'b0;
        chk("flow_handshake_busy", busy, 1'b0);
        chk("flow_handshake_valid", res_valid, 1'b0);
        @(negedge clk);
        chk("flow_start_in_report_ignored", busy, 1'b0);

        // Saturation: 8xA vs 8xA; 4-bit engine clamps at 15
        do_start(7'd8, 128'h0);
        send_target(32'h0, 8, 1'b0);
        wait_result("sat", 16, 8, 8, 15, 17);

        // Reset in the middle of a stream
        do_start(7'd4, 128'h9C);
        t_valid = 1'b1; t_data = 2'b00;
        @(negedge clk);
        t_data = 2'b11;
        @(negedge clk);
        t_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_t_ready", t_ready, 1'b0);
        chk("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_res_score", res_score, 0);
        chk("midrst_res_t_pos", res_t_pos, 0);
        chk("midrst_res_q_pos", res_q_pos, 0);
        chk("midrst_b_busy", b_busy, 1'b0);
        @(negedge clk);

        do_start(7'd4, 128'h9C);
        send_target(32'h9C, 4, 1'b0);
        wait_result("after_rst", 8, 4, 4, 8, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
